// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state type for the sequential ALU and its
// iterative multiply/divide unit.
package alu_seq_pkg;

   localparam logic [6:0] ALU_ADD  = 7'd0;
   localparam logic [6:0] ALU_ADC  = 7'd1;
   localparam logic [6:0] ALU_SUB  = 7'd2;
   localparam logic [6:0] ALU_SBC  = 7'd3;
   localparam logic [6:0] ALU_AND  = 7'd4;
   localparam logic [6:0] ALU_OR   = 7'd5;
   localparam logic [6:0] ALU_XOR  = 7'd6;
   localparam logic [6:0] ALU_SHL  = 7'd7;
   localparam logic [6:0] ALU_SHR  = 7'd8;
   localparam logic [6:0] ALU_SAR  = 7'd9;
   localparam logic [6:0] ALU_MUL  = 7'd10;
   localparam logic [6:0] ALU_DIVU = 7'd11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   function automatic logic is_iter(input logic [6:0] op, input logic b_zero);
      return (op == ALU_MUL) || ((op == ALU_DIVU) && !b_zero);
   endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// clock. done/lo/hi present the final step's values so the caller can register them.
module alu_muldiv #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] lo,
   output logic [N-1:0] hi
);

   localparam int CW = $clog2(N);

   logic          busy;
   logic          mode_r;
   logic [CW-1:0] cnt;
   logic [N-1:0]  acc, q, dv;
   logic [N-1:0]  acc_n, q_n;
   logic [N:0]    t, diff;

   // MUL: {acc,q} shifts right with the partial sum; DIVU: remainder in acc,
   // quotient bits enter q from the right as the dividend leaves it.
   always_comb begin
      t     = '0;
      diff  = '0;
      acc_n = acc;
      q_n   = q;
      if (!mode_r) begin
         t     = {1'b0, acc} + (q[0] ? {1'b0, dv} : '0);
         acc_n = t[N:1];
         q_n   = {t[0], q[N-1:1]};
      end else begin
         t    = {acc, q[N-1]};
         diff = t - {1'b0, dv};
         if (!diff[N]) begin
            acc_n = diff[N-1:0];
            q_n   = {q[N-2:0], 1'b1};
         end else begin
            acc_n = t[N-1:0];
            q_n   = {q[N-2:0], 1'b0};
         end
      end
   end

   assign done = busy && (cnt == CW'(N - 1));
   assign lo   = q_n;
   assign hi   = acc_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         mode_r <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         q      <= '0;
         dv     <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         mode_r <= mode;
         cnt    <= '0;
         acc    <= '0;
         q      <= a;
         dv     <= b;
      end else if (busy) begin
         acc <= acc_n;
         q   <= q_n;
         cnt <= cnt + CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops register in one
// clock, MUL/DIVU iterate in alu_muldiv; the result is held until consumed.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int N   = 8,
   parameter int SHW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [6:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic [N-1:0] hi,
   output logic         cout,
   output logic         overflow,
   output logic         sign,
   output logic         zero,
   output logic         err
);

   state_t         state, state_n;
   logic           accept, md_start, md_done, is_mul;
   logic [N-1:0]   md_lo, md_hi;
   logic [SHW-1:0] s;
   logic [N:0]     wide;
   logic [N-1:0]   sc_out, sc_hi;
   logic           sc_cout, sc_ovf, sc_err;

   assign accept   = (state == ST_IDLE) && in_valid;
   assign md_start = accept && is_iter(op, b == '0);
   assign s        = b[SHW-1:0];

   alu_muldiv #(.N(N)) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_start),
      .mode  (op == ALU_DIVU),
      .a     (a),
      .b     (b),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi)
   );

   always_comb begin
      wide    = '0;
      sc_out  = '0;
      sc_hi   = '0;
      sc_cout = 1'b0;
      sc_ovf  = 1'b0;
      sc_err  = 1'b0;
      case (op)
         ALU_ADD, ALU_ADC: begin
            wide    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, (op == ALU_ADC) & cin};
            sc_out  = wide[N-1:0];
            sc_cout = wide[N];
            sc_ovf  = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
         end
         ALU_SUB, ALU_SBC: begin
            wide    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, (op == ALU_SUB) | cin};
            sc_out  = wide[N-1:0];
            sc_cout = wide[N];
            sc_ovf  = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
         end
         ALU_AND: sc_out = a & b;
         ALU_OR:  sc_out = a | b;
         ALU_XOR: sc_out = a ^ b;
         // The extra guard bit catches the last bit shifted out (0 when s==0).
         ALU_SHL: begin
            wide    = {1'b0, a} << s;
            sc_out  = wide[N-1:0];
            sc_cout = wide[N];
         end
         ALU_SHR: begin
            wide    = {a, 1'b0} >> s;
            sc_out  = wide[N:1];
            sc_cout = wide[0];
         end
         ALU_SAR: begin
            wide    = $signed({a, 1'b0}) >>> s;
            sc_out  = wide[N:1];
            sc_cout = wide[0];
         end
         ALU_MUL: ;
         ALU_DIVU: begin
            sc_out = '1;
            sc_hi  = a;
            sc_ovf = 1'b1;
         end
         default: sc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (in_valid) state_n = md_start ? ST_BUSY : ST_DONE;
         ST_BUSY: if (md_done) state_n = ST_DONE;
         ST_DONE: if (out_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out      <= '0;
         hi       <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         err      <= 1'b0;
         is_mul   <= 1'b0;
      end else if (accept) begin
         if (md_start) begin
            is_mul <= (op == ALU_MUL);
         end else begin
            out      <= sc_out;
            hi       <= sc_hi;
            cout     <= sc_cout;
            overflow <= sc_ovf;
            err      <= sc_err;
         end
      end else if ((state == ST_BUSY) && md_done) begin
         out      <= md_lo;
         hi       <= md_hi;
         cout     <= 1'b0;
         overflow <= is_mul && (md_hi != '0);
         err      <= 1'b0;
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign sign      = out[N-1];
   assign zero      = (out == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes model results, a monitor pops
// and compares them (plus latency and hold stability) whenever out_valid rises.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int N   = 8;
   localparam int SHW = 3;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
   logic [6:0]   op = '0;
   logic [N-1:0] a = '0, b = '0;
   logic         in_ready, out_valid, cout, overflow, sign, zero, err;
   logic [N-1:0] out, hi;

   alu_seq #(.N(N), .SHW(SHW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .hi(hi), .cout(cout),
      .overflow(overflow), .sign(sign), .zero(zero), .err(err)
   );

   typedef struct {
      logic [N-1:0] out, hi;
      logic         cout, ovf, sgn, zro, err;
      int           lat, t0;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0, n_pass = 0, n_total = 0;
   bit   rand_rdy = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [6:0] o, input int ai, input int bi, input int ci);
      exp_t e;
      int mask = (1 << N) - 1, half = 1 << (N - 1);
      int sa = (ai >= half) ? ai - (1 << N) : ai;
      int sb = (bi >= half) ? bi - (1 << N) : bi;
      int s  = bi % N;
      int r, bw;
      e.out = '0; e.hi = '0; e.cout = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
      e.lat = 1; e.t0 = 0;
      case (o)
         ALU_ADD, ALU_ADC: begin
            r = ai + bi + ((o == ALU_ADC) ? ci : 0);
            e.out = N'(r & mask); e.cout = (r > mask);
            r = sa + sb + ((o == ALU_ADC) ? ci : 0);
            e.ovf = (r > half - 1) || (r < -half);
         end
         ALU_SUB, ALU_SBC: begin
            bw = (o == ALU_SBC) ? 1 - ci : 0;
            r = ai - bi - bw;
            e.out = N'(r & mask); e.cout = (r >= 0);
            r = sa - sb - bw;
            e.ovf = (r > half - 1) || (r < -half);
         end
         ALU_AND: e.out = N'(ai & bi);
         ALU_OR:  e.out = N'(ai | bi);
         ALU_XOR: e.out = N'(ai ^ bi);
         ALU_SHL: begin
            e.out = N'((ai << s) & mask);
            e.cout = (s != 0) && (((ai >> (N - s)) & 1) == 1);
         end
         ALU_SHR: begin
            e.out = N'(ai >> s);
            e.cout = (s != 0) && (((ai >> (s - 1)) & 1) == 1);
         end
         ALU_SAR: begin
            e.out = N'((sa >>> s) & mask);
            e.cout = (s != 0) && (((ai >> (s - 1)) & 1) == 1);
         end
         ALU_MUL: begin
            r = ai * bi;
            e.out = N'(r & mask); e.hi = N'(r >> N);
            e.ovf = (e.hi != 0); e.lat = N + 1;
         end
         ALU_DIVU: begin
            if (bi == 0) begin
               e.out = N'(mask); e.hi = N'(ai); e.ovf = 1'b1;
            end else begin
               e.out = N'(ai / bi); e.hi = N'(ai % bi); e.lat = N + 1;
            end
         end
         default: e.err = 1'b1;
      endcase
      e.sgn = e.out[N-1];
      e.zro = (e.out == 0);
      return e;
   endfunction

   exp_t         cur;
   bit           held = 1'b0;
   logic [2*N+4:0] snap;

   always @(negedge clk) begin
      if (!rst_n || !out_valid) begin
         held = 1'b0;
      end else if (!held) begin
         held = 1'b1;
         snap = {out, hi, cout, overflow, sign, zero, err};
         if (sbq.size() == 0) begin
            check("spurious_out_valid", 1, 0);
         end else begin
            cur = sbq.pop_front();
            check("out", longint'(out), longint'(cur.out));
            check("hi", longint'(hi), longint'(cur.hi));
            check("cout", longint'(cout), longint'(cur.cout));
            check("overflow", longint'(overflow), longint'(cur.ovf));
            check("sign", longint'(sign), longint'(cur.sgn));
            check("zero", longint'(zero), longint'(cur.zro));
            check("err", longint'(err), longint'(cur.err));
            check("latency", longint'(cyc - cur.t0), longint'(cur.lat));
            check("in_ready_in_done", longint'(in_ready), 0);
         end
      end else begin
         check("hold_stable", longint'({out, hi, cout, overflow, sign, zero, err}), longint'(snap));
      end
   end

   task automatic issue(input logic [6:0] o, input int ai, input int bi, input logic ci);
      exp_t e;
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      op = o; a = N'(ai); b = N'(bi); cin = ci; in_valid = 1'b1;
      e = model(o, ai, bi, int'(ci));
      e.t0 = cyc;
      sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
      op = 7'($urandom_range(0, 15));
   endtask

   task automatic drain();
      int w = 0;
      while ((sbq.size() != 0 || !in_ready) && w < 300) begin
         @(negedge clk);
         w++;
      end
      check("drain", longint'(sbq.size() == 0 && in_ready), 1);
   endtask

   logic [6:0] ops[14] = '{ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR, ALU_XOR,
                          ALU_SHL, ALU_SHR, ALU_SAR, ALU_MUL, ALU_DIVU, 7'd12, 7'd127};

   initial begin
      int w;
      repeat (2) @(negedge clk);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_hi", longint'({out, hi}), 0);
      check("rst_flags", longint'({cout, overflow, sign, err}), 0);
      check("rst_zero", longint'(zero), 1);
      rst_n = 1'b1;

      issue(ALU_ADD, 255, 1, 0);
      issue(ALU_ADD, 127, 127, 0);
      issue(ALU_ADD, 255, 255, 0);
      issue(ALU_ADC, 127, 0, 1);
      issue(ALU_SUB, 5, 7, 0);
      issue(ALU_SBC, 10, 3, 0);
      issue(ALU_SBC, 128, 0, 0);
      issue(ALU_MUL, 15, 17, 0);
      issue(ALU_MUL, 16, 16, 0);
      issue(ALU_DIVU, 200, 7, 0);
      issue(ALU_DIVU, 13, 0, 0);
      issue(ALU_SHL, 8'h81, 1, 0);
      issue(ALU_SHL, 8'h81, 8, 0);
      issue(ALU_SHR, 8'h81, 1, 0);
      issue(ALU_SAR, 8'h81, 3, 0);
      issue(ALU_AND, 8'hF0, 8'h3C, 0);
      issue(ALU_XOR, 8'hAA, 8'hAA, 0);
      issue(7'd100, 1, 2, 1);
      drain();

      // Backpressure: result held while out_ready=0; operands toggle during BUSY.
      out_ready = 1'b0;
      issue(ALU_MUL, 15, 17, 0);
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("bp_out_valid_seen", longint'(out_valid), 1);
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", longint'(in_ready), 0);
         check("bp_out_valid", longint'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", longint'({in_ready, out_valid}), 2);
      drain();

      // Asynchronous reset in the middle of a multiply.
      issue(ALU_MUL, 200, 100, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      check("mid_rst_out_valid", longint'(out_valid), 0);
      check("mid_rst_in_ready", longint'(in_ready), 1);
      check("mid_rst_zero", longint'(zero), 1);
      @(negedge clk);
      rst_n = 1'b1;
      issue(ALU_ADD, 3, 4, 0);
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 80; i++) begin
         int bi = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         issue(ops[$urandom_range(0, 13)], int'($urandom_range(0, 255)), bi, 1'($urandom));
      end
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
